kb_fifo: RTL and testbench
==========================

Name: kb_fifo

Overview:
- Keyboard scancode buffer between the PS/2 receiver (`done`/`data` strobe) and the CPU port router (keyboard data/status ports).
- Folds PS/2 set-2 prefixes (E0 extended, F0 release) into per-entry flags.
- Queues decoded keys in a first-word-fall-through FIFO and raises a one-cycle IRQ strobe per queued key for the interrupt queue logic.
- Lets the CPU read bursts of keys without losing bytes between interrupts.

Parameters:
- ADDR_W, 4, FIFO address width. Depth = 2**ADDR_W entries (default 16).

Ports:
- clock, input, 1: system clock (25 MHz CPU/peripheral domain).
- reset, input, 1: synchronous, active-high reset.
- kb_done, input, 1: one-cycle strobe, kb_data valid.
- kb_data, input, 8: raw PS/2 byte.
- rd, input, 1: one-cycle pop strobe (CPU read of data port completed).
- clr, input, 1: one-cycle flush strobe (CPU write to status port).
- q, output, 8: head entry scancode.
- q_ext, output, 1: head entry was E0-prefixed.
- q_rel, output, 1: head entry was F0-prefixed (key release).
- empty, output, 1: FIFO holds no entries.
- full, output, 1: FIFO holds 2**ADDR_W entries.
- count, output, ADDR_W+1: number of stored entries, 0..2**ADDR_W.
- overflow, output, 1: sticky flag, a decoded key was dropped.
- irq, output, 1: one-cycle pulse per accepted entry.

Behaviour:
- Reset (synchronous, reset=1 at clock edge) sets:
  - count=0, write/read pointers=0, empty=1, full=0;
  - overflow=0, irq=0, q/q_ext/q_rel=0;
  - decoder state=IDLE.
- Reset has priority over all other inputs.
- Prefix decoder: 4 states IDLE, E0, F0, E0F0. A transition happens only on kb_done=1.
  - IDLE: E0 -> E0; F0 -> F0; any other byte -> push {rel=0, ext=0, code}, stay IDLE.
  - E0: F0 -> E0F0; E0 -> E0; other -> push {0,1,code} -> IDLE.
  - F0: F0 -> F0; E0 -> E0F0; other -> push {1,0,code} -> IDLE.
  - E0F0: E0 or F0 -> E0F0; other -> push {1,1,code} -> IDLE.
  - E1, AA, FA, FE and all other non-prefix bytes are pushed as plain codes with the current flags.
- Storage: 10-bit entries {rel, ext, code[7:0]}, register or RAM array, first-word fall-through.
  - q/q_ext/q_rel always show the entry at the read pointer.
  - Their value is don't-care while empty=1; the bench checks them only when empty=0.
- Push latency: a push generated on the kb_done cycle is written at that edge. empty, count and q reflect it on the next cycle. irq=1 for exactly that next cycle.
- Pop: rd=1 with empty=0 advances the read pointer and decrements count at the edge. rd=1 with empty=1 is ignored and leaves no side effects.
- Simultaneous push and pop:
  - Both are performed and count is unchanged.
  - When full, the pop frees a slot, so the push is accepted with no overflow.
  - When empty, the push is accepted, the pop is ignored, and count becomes 1.
- Push while full without pop: the entry is dropped, pointers and count are unchanged, overflow<=1, irq stays 0.
- Pointers wrap modulo 2**ADDR_W.
- Status outputs: full = (count == 2**ADDR_W); empty = (count == 0). Both are registered or derived from registered count, with no combinational path from inputs.
- clr: same-cycle priority over push and pop.
  - Sets count=0, pointers=0, overflow=0, decoder=IDLE.
  - A kb_done in the clr cycle is discarded.
  - irq is 0 on the cycle after clr.
- A prefix byte never produces irq and never changes count.
- A reset or clr between a prefix and its code discards the pending prefix; the next code is pushed with flags 0.

Test Plan:
- Reset, then kb_done with 0x1C -> next cycle: empty=0, count=1, q=0x1C, q_ext=0, q_rel=0, irq high for 1 cycle. Then rd -> empty=1, count=0.
- Sequence E0, F0, 0x75 (one strobe each, gaps of 3 cycles) -> exactly one entry q=0x75, q_ext=1, q_rel=1. irq fires only once, after the 0x75 strobe.
- Push 17 plain codes 0x01..0x11 with no reads (ADDR_W=4) -> full=1, count=16, overflow=1 after the 17th. Popping 16 times yields 0x01..0x10 in order, then empty=1.
- With full=1, assert rd and kb_done (0x22) in the same cycle -> count stays 16, overflow stays 0, irq pulses. After draining, 0x22 is the last entry.
- F0 strobe, then clr, then 0x1C -> entry q=0x1C, q_rel=0. overflow cleared, count=1.
- rd pulsed while empty, and reset asserted mid-burst after 5 pushes -> no underflow (count stays 0). After reset: count=0, empty=1, overflow=0, irq=0, next push lands at q correctly.

Source files
------------

// File: rtl/kb_fifo_if.sv
// Keyboard FIFO bus: PS/2 receiver strobe, CPU pop/flush strobes and the
// head-entry / status view presented back to the CPU port router.
interface kb_fifo_if #(
   parameter int ADDR_W = 4
);
   logic              kb_done;
   logic [7:0]        kb_data;
   logic              rd;
   logic              clr;
   logic [7:0]        q;
   logic              q_ext;
   logic              q_rel;
   logic              empty;
   logic              full;
   logic [ADDR_W:0]   count;
   logic              overflow;
   logic              irq;

   // Side that feeds bytes and strobes and observes the queue
   modport master (
      output kb_done, kb_data, rd, clr,
      input  q, q_ext, q_rel, empty, full, count, overflow, irq
   );

   // The FIFO itself
   modport slave (
      input  kb_done, kb_data, rd, clr,
      output q, q_ext, q_rel, empty, full, count, overflow, irq
   );
endinterface

// File: rtl/kb_fifo.sv
// Keyboard scancode buffer: folds PS/2 set-2 E0/F0 prefixes into per-entry
// flags, queues decoded keys in a first-word-fall-through FIFO and pulses
// irq once for every key that is actually stored.
module kb_fifo #(
   parameter int ADDR_W = 4
) (
   input  logic      clock,
   input  logic      reset,
   kb_fifo_if.slave  bus
);

   localparam int              DEPTH    = 1 << ADDR_W;
   localparam logic [ADDR_W:0] FULL_CNT = DEPTH[ADDR_W:0];

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_E0   = 2'd1,
      ST_F0   = 2'd2,
      ST_E0F0 = 2'd3
   } dec_state_t;

   dec_state_t state_reg, state_next;

   // Entry layout: [9]=release, [8]=extended, [7:0]=scancode
   logic [9:0]        mem [DEPTH];
   logic [9:0]        head_reg;
   logic [ADDR_W-1:0] wr_ptr_reg, rd_ptr_reg;
   logic [ADDR_W-1:0] wr_ptr_next, rd_ptr_next;
   logic [ADDR_W:0]   count_reg, count_next;
   logic              overflow_reg;
   logic              irq_reg;

   logic              is_prefix;
   logic              push_req;
   logic [9:0]        push_data;
   logic              empty_w, full_w;
   logic              do_pop, do_push, drop;

   assign empty_w = (count_reg == '0);
   assign full_w  = (count_reg == FULL_CNT);

   // Decoder state register; a flush or reset drops any pending prefix
   always_ff @(posedge clock) begin
      if (reset || bus.clr)
         state_reg <= ST_IDLE;
      else
         state_reg <= state_next;
   end

   // Decoder next state: prefixes accumulate, any other byte returns to idle
   always_comb begin
      state_next = state_reg;
      if (bus.kb_done) begin
         unique case (state_reg)
            ST_IDLE: begin
               if (bus.kb_data == 8'hE0)      state_next = ST_E0;
               else if (bus.kb_data == 8'hF0) state_next = ST_F0;
               else                           state_next = ST_IDLE;
            end
            ST_E0: begin
               if (bus.kb_data == 8'hE0)      state_next = ST_E0;
               else if (bus.kb_data == 8'hF0) state_next = ST_E0F0;
               else                           state_next = ST_IDLE;
            end
            ST_F0: begin
               if (bus.kb_data == 8'hE0)      state_next = ST_E0F0;
               else if (bus.kb_data == 8'hF0) state_next = ST_F0;
               else                           state_next = ST_IDLE;
            end
            ST_E0F0: begin
               if (is_prefix) state_next = ST_E0F0;
               else           state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // Decoder output: non-prefix bytes become a push carrying the current flags
   always_comb begin
      is_prefix = (bus.kb_data == 8'hE0) || (bus.kb_data == 8'hF0);
      push_req  = bus.kb_done && !is_prefix;
      push_data = {(state_reg == ST_F0) || (state_reg == ST_E0F0),
                   (state_reg == ST_E0) || (state_reg == ST_E0F0),
                   bus.kb_data};
   end

   // FIFO control: a pop while full frees the slot the same-cycle push uses
   always_comb begin
      do_pop      = bus.rd && !empty_w;
      do_push     = push_req && (!full_w || do_pop);
      drop        = push_req && full_w && !do_pop;
      rd_ptr_next = do_pop  ? rd_ptr_reg + 1'b1 : rd_ptr_reg;
      wr_ptr_next = do_push ? wr_ptr_reg + 1'b1 : wr_ptr_reg;
      count_next  = count_reg;
      if (do_push && !do_pop)
         count_next = count_reg + 1'b1;
      else if (do_pop && !do_push)
         count_next = count_reg - 1'b1;
   end

   // Pointer, count and flag registers; flush beats push and pop
   always_ff @(posedge clock) begin
      if (reset || bus.clr) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         count_reg    <= '0;
         overflow_reg <= 1'b0;
         irq_reg      <= 1'b0;
      end else begin
         wr_ptr_reg   <= wr_ptr_next;
         rd_ptr_reg   <= rd_ptr_next;
         count_reg    <= count_next;
         overflow_reg <= overflow_reg | drop;
         irq_reg      <= do_push;
      end
   end

   // Storage array write port (no reset so it can map to RAM)
   always_ff @(posedge clock) begin
      if (do_push && !reset && !bus.clr)
         mem[wr_ptr_reg] <= push_data;
   end

   // Registered head: read the entry at the next read pointer, bypassing the
   // entry being written when it lands exactly there (empty or last-entry pop)
   always_ff @(posedge clock) begin
      if (reset || bus.clr)
         head_reg <= '0;
      else if (do_push && (wr_ptr_reg == rd_ptr_next))
         head_reg <= push_data;
      else
         head_reg <= mem[rd_ptr_next];
   end

   assign bus.q        = head_reg[7:0];
   assign bus.q_ext    = head_reg[8];
   assign bus.q_rel    = head_reg[9];
   assign bus.empty    = empty_w;
   assign bus.full     = full_w;
   assign bus.count    = count_reg;
   assign bus.overflow = overflow_reg;
   assign bus.irq      = irq_reg;

endmodule

// File: tb/tb_kb_fifo.sv
// Directed bench for kb_fifo: a reference decoder plus a scoreboard queue of
// expected entries; every step compares status, irq and the head entry.
module tb_kb_fifo;

   localparam int ADDR_W = 4;
   localparam int DEPTH  = 1 << ADDR_W;

   logic clock = 1'b0;
   logic reset = 1'b1;

   kb_fifo_if #(.ADDR_W(ADDR_W)) bus ();

   kb_fifo #(.ADDR_W(ADDR_W)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   // 25 MHz
   always #20 clock = ~clock;

   logic [9:0] sb [$];
   bit         m_ext, m_rel, m_ovf;
   int         pass_cnt  = 0;
   int         fail_cnt  = 0;
   int         total_cnt = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total_cnt++;
      assert (obs === exp) pass_cnt++;
      else begin
         fail_cnt++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input bit exp_irq);
      check("empty",    {31'd0, bus.empty},    {31'd0, sb.size() == 0});
      check("full",     {31'd0, bus.full},     {31'd0, sb.size() == DEPTH});
      check("count",    {27'd0, bus.count},    sb.size());
      check("overflow", {31'd0, bus.overflow}, {31'd0, m_ovf});
      check("irq",      {31'd0, bus.irq},      {31'd0, exp_irq});
      if (sb.size() > 0) begin
         check("q",     {24'd0, bus.q},     {24'd0, sb[0][7:0]});
         check("q_ext", {31'd0, bus.q_ext}, {31'd0, sb[0][8]});
         check("q_rel", {31'd0, bus.q_rel}, {31'd0, sb[0][9]});
      end
   endtask

   // One clock: update the model, drive strobes, sample #1 after the edge
   task automatic step(input bit d, input logic [7:0] b, input bit r, input bit c);
      bit         exp_irq;
      bit         pop;
      bit         want;
      logic [9:0] ent;
      exp_irq = 1'b0;
      pop     = 1'b0;
      want    = 1'b0;
      ent     = '0;
      if (c) begin
         sb.delete();
         m_ext = 1'b0;
         m_rel = 1'b0;
         m_ovf = 1'b0;
      end else begin
         pop = r && (sb.size() > 0);
         if (d) begin
            if (b == 8'hE0)      m_ext = 1'b1;
            else if (b == 8'hF0) m_rel = 1'b1;
            else begin
               want  = 1'b1;
               ent   = {m_rel, m_ext, b};
               m_ext = 1'b0;
               m_rel = 1'b0;
            end
         end
         if (pop) void'(sb.pop_front());
         if (want) begin
            if (sb.size() < DEPTH) begin
               sb.push_back(ent);
               exp_irq = 1'b1;
            end else begin
               m_ovf = 1'b1;
            end
         end
      end
      @(negedge clock);
      bus.kb_done = d;
      bus.kb_data = b;
      bus.rd      = r;
      bus.clr     = c;
      @(posedge clock);
      #1;
      bus.kb_done = 1'b0;
      bus.rd      = 1'b0;
      bus.clr     = 1'b0;
      if (d || r || c)
         $display("t=%0t done=%b data=%h rd=%b clr=%b -> count=%0d q=%h ext=%b rel=%b irq=%b ovf=%b",
                  $time, d, b, r, c, bus.count, bus.q, bus.q_ext, bus.q_rel, bus.irq, bus.overflow);
      check_state(exp_irq);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0);
   endtask

   // Reset with strobes active to show reset priority, then check reset state
   task automatic do_reset();
      @(negedge clock);
      reset       = 1'b1;
      bus.kb_done = 1'b1;
      bus.kb_data = 8'h33;
      bus.rd      = 1'b1;
      @(posedge clock);
      #1;
      bus.kb_done = 1'b0;
      bus.rd      = 1'b0;
      @(posedge clock);
      @(negedge clock);
      reset = 1'b0;
      sb.delete();
      m_ext = 1'b0;
      m_rel = 1'b0;
      m_ovf = 1'b0;
      $display("t=%0t reset -> count=%0d empty=%b ovf=%b irq=%b", $time, bus.count, bus.empty, bus.overflow, bus.irq);
      check_state(1'b0);
      check("rst_q",     {24'd0, bus.q},     32'd0);
      check("rst_q_ext", {31'd0, bus.q_ext}, 32'd0);
      check("rst_q_rel", {31'd0, bus.q_rel}, 32'd0);
   endtask

   initial begin
      bus.kb_done = 1'b0;
      bus.kb_data = 8'h00;
      bus.rd      = 1'b0;
      bus.clr     = 1'b0;

      do_reset();

      // Single plain key, irq for exactly one cycle, then pop
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // E0 F0 75 with gaps: one extended release entry
      step(1'b1, 8'hE0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      idle(3);
      step(1'b1, 8'h75, 1'b0, 1'b0);
      idle(1);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Fill past full: 17 codes, last one dropped
      for (int i = 1; i <= 17; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Pending F0 discarded by clr, overflow cleared
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b1, 8'h1C, 1'b0, 1'b0);

      // Full with simultaneous pop and push
      step(1'b1, 8'h99, 1'b0, 1'b1);
      for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0);
      step(1'b1, 8'h22, 1'b1, 1'b0);
      for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0);

      // Push+pop when empty and with one entry (head bypass)
      step(1'b1, 8'h2B, 1'b1, 1'b0);
      step(1'b1, 8'h2C, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Underflow attempts, then reset mid-burst
      step(1'b0, 8'h00, 1'b1, 1'b0);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h5A, 1'b0, 1'b0);

      // Reset between prefix and code drops the prefix
      step(1'b1, 8'hF0, 1'b0, 1'b0);
      do_reset();
      step(1'b1, 8'h1C, 1'b0, 1'b0);
      idle(1);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
